// File: rtl/gf_log_table.sv
// GF(2^8) logarithm unit: builds a log RAM by walking the powers of 0x03 after reset,
// then answers base-0x03 log lookups over a valid/ready stream with one cycle of latency.
module gf_log_table #(
   parameter logic [7:0] POLY = 8'h1B
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] l,
   output logic       zero,
   output logic       init_done
);

   typedef enum logic {StInit, StReady} state_e;

   state_e     state_q, state_d;
   logic [7:0] p_q, p_d;
   logic [7:0] i_q, i_d;
   logic [7:0] l_q, l_d;
   logic       out_valid_q, out_valid_d;
   logic       zero_q, zero_d;
   logic       init_done_q, init_done_d;

   logic [7:0] mem [256];
   logic [7:0] xtime_p;
   logic       accept;
   logic       mem_we;

   // p * 0x03 == xtime(p) ^ p in the AES field
   always_comb begin
      xtime_p = {p_q[6:0], 1'b0} ^ (p_q[7] ? POLY : 8'h00);
   end

   assign in_ready = (state_q == StReady) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign mem_we   = (state_q == StInit) && !rst;

   always_comb begin
      state_d     = state_q;
      p_d         = p_q;
      i_d         = i_q;
      l_d         = l_q;
      out_valid_d = out_valid_q;
      zero_d      = zero_q;
      init_done_d = init_done_q;
      unique case (state_q)
         StInit: begin
            p_d = xtime_p ^ p_q;
            i_d = i_q + 8'd1;
            if (i_q == 8'hFE) begin
               state_d     = StReady;
               init_done_d = 1'b1;
            end
         end
         StReady: begin
            if (accept) begin
               out_valid_d = 1'b1;
               // mem[0x00] is never written, so a zero input bypasses the RAM
               if (a == 8'h00) begin
                  l_d    = 8'h00;
                  zero_d = 1'b1;
               end else begin
                  l_d    = mem[a];
                  zero_d = 1'b0;
               end
            end else if (out_ready) begin
               out_valid_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StInit;
         p_q         <= 8'h01;
         i_q         <= 8'h00;
         l_q         <= 8'h00;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         p_q         <= p_d;
         i_q         <= i_d;
         l_q         <= l_d;
         out_valid_q <= out_valid_d;
         zero_q      <= zero_d;
         init_done_q <= init_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[p_q] <= i_q;
      end
   end

   assign out_valid = out_valid_q;
   assign l         = l_q;
   assign zero      = zero_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_gf_log_table.sv
// Self-checking bench for gf_log_table: reference log/exp tables are built from a generic
// GF(2^8) multiply, then compared against directed, sweep, backpressure and random traffic.
module tb_gf_log_table;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] l;
   logic       zero;
   logic       init_done;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_ref [256];
   logic [7:0] log_ref [256];

   always #5 clk = ~clk;

   gf_log_table #(.POLY(8'h1B)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .l         (l),
      .zero      (zero),
      .init_done (init_done)
   );

   // Schoolbook carry-less multiply followed by reduction modulo 0x11B
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [15:0] prod;
      prod = 16'h0000;
      for (int b = 0; b < 8; b++) if (y[b]) prod = prod ^ (16'(x) << b);
      for (int b = 15; b >= 8; b--) if (prod[b]) prod = prod ^ (16'h011B << (b - 8));
      return prod[7:0];
   endfunction

   function automatic logic [7:0] ref_log(input logic [7:0] v);
      return (v == 8'h00) ? 8'h00 : log_ref[v];
   endfunction

   task automatic build_model();
      logic [7:0] v;
      v = 8'h01;
      log_ref[0] = 8'h00;
      exp_ref[255] = 8'h01;
      for (int k = 0; k < 255; k++) begin
         exp_ref[k] = v;
         log_ref[v] = 8'(k);
         v = gf_mul(v, 8'h03);
      end
   endtask

   // Counts cycles until init_done; in_ready/out_valid must stay low meanwhile
   task automatic wait_init(output int cyc);
      int bad;
      cyc = 0;
      bad = 0;
      while (!init_done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (!init_done && (in_ready !== 1'b0 || out_valid !== 1'b0)) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL init_quiet: %0d cycles with in_ready/out_valid high, required 0", bad);
      end
      checks++;
      if (cyc != 255 || init_done !== 1'b1) begin
         errors++;
         $display("FAIL init_latency: init_done after %0d cycles (init_done=%b), required 255",
                  cyc, init_done);
      end
   endtask

   // Single request with out_ready high; result sampled one cycle after accept
   task automatic lookup(input logic [7:0] av, input string name);
      int t;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = av;
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || l !== ref_log(av) || zero !== (av == 8'h00)) begin
         errors++;
         $display("FAIL %s: a=%02h got valid=%b l=%02h zero=%b, required valid=1 l=%02h zero=%b",
                  name, av, out_valid, l, zero, ref_log(av), av == 8'h00);
      end
   endtask

   task automatic test_reset();
      int cyc;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a         = 8'h03;
      rst       = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || l !== 8'h00 || zero !== 1'b0 ||
          init_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: rdy=%b vld=%b l=%02h zero=%b done=%b, required all 0",
                  in_ready, out_valid, l, zero, init_done);
      end
      rst = 1'b0;
      wait_init(cyc);
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [7:0] av [7] = '{8'h01, 8'h03, 8'h05, 8'hFF, 8'h1A, 8'h02, 8'hF6};
      logic [7:0] lv [7] = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h08, 8'h19, 8'hFE};
      for (int k = 0; k < 7; k++) begin
         lookup(av[k], "directed_model");
         checks++;
         if (l !== lv[k] || zero !== 1'b0) begin
            errors++;
            $display("FAIL directed: a=%02h got l=%02h zero=%b, required l=%02h zero=0",
                     av[k], l, zero, lv[k]);
         end
      end
   endtask

   task automatic test_zero();
      lookup(8'h00, "zero_input");
      @(negedge clk);
   endtask

   task automatic test_sweep();
      logic [255:0] seen;
      int bad;
      int distinct;
      seen = '0;
      bad = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int v = 1; v < 256; v++) begin
         a = 8'(v);
         @(negedge clk);
         if (out_valid !== 1'b1 || l !== log_ref[v] || zero !== 1'b0 ||
             exp_ref[l] !== 8'(v)) begin
            bad++;
            if (bad < 5)
               $display("FAIL sweep: a=%02h got valid=%b l=%02h zero=%b, required l=%02h",
                        v, out_valid, l, zero, log_ref[v]);
         end
         if (!$isunknown(l)) seen[l] = 1'b1;
      end
      in_valid = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL sweep_total: %0d bad results, required 0", bad);
      end
      distinct = $countones(seen);
      checks++;
      if (distinct != 255 || seen[255] !== 1'b0) begin
         errors++;
         $display("FAIL sweep_perm: %0d distinct logs (ff seen=%b), required 255 and 0",
                  distinct, seen[255]);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int bad;
      bad = 0;
      lookup(8'h03, "bp_first");
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = 8'h05;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (l !== 8'h01 || out_valid !== 1'b1 || zero !== 1'b0 || in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_hold: %0d cycles with l/valid/in_ready changed, required 0", bad);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || l !== 8'h02) begin
         errors++;
         $display("FAIL bp_release: valid=%b l=%02h, required valid=1 l=02", out_valid, l);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_reset_mid_init();
      int cyc;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 100; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_init: valid=%b done=%b, required 0 0", out_valid, init_done);
      end
      wait_init(cyc);
      lookup(8'h03, "rst_mid_init_lookup");
   endtask

   task automatic test_reset_pending();
      int cyc;
      lookup(8'h05, "pending_setup");
      out_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_pending: valid=%b done=%b, required 0 0", out_valid, init_done);
      end
      wait_init(cyc);
      lookup(8'h03, "rst_pending_lookup");
   endtask

   task automatic test_random();
      logic       mv;
      logic [7:0] ml;
      logic       mz;
      logic       iv;
      logic       ordy;
      logic [7:0] av;
      logic       mrdy;
      int         bad;
      mv = 1'b0;
      ml = 8'h00;
      mz = 1'b0;
      bad = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      for (int n = 0; n < 400; n++) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         av   = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         in_valid  = iv;
         out_ready = ordy;
         a         = av;
         mrdy = !mv || ordy;
         #1;
         if (in_ready !== mrdy) bad++;
         @(negedge clk);
         if (iv && mrdy) begin
            mv = 1'b1;
            ml = ref_log(av);
            mz = (av == 8'h00);
         end else if (ordy) begin
            mv = 1'b0;
         end
         if (out_valid !== mv || (mv && (l !== ml || zero !== mz))) begin
            bad++;
            if (bad < 5)
               $display("FAIL random_step %0d: valid=%b l=%02h zero=%b, required %b %02h %b",
                        n, out_valid, l, zero, mv, ml, mz);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL random_total: %0d mismatching cycles, required 0", bad);
      end
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = 8'h00;
      build_model();
      test_reset();
      test_directed();
      test_zero();
      test_sweep();
      test_backpressure();
      test_random();
      test_reset_mid_init();
      test_reset_pending();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gf_log_table.md
Name: gf_log_table

Overview:
- GF(2^8) logarithm unit: the inverse of the exponent (antilog) table. It returns l such that 0x03^l = a, using the AES field polynomial x^8+x^4+x^3+x+1.
- After reset it builds an internal 256-entry log RAM by walking the powers of 0x03. It then serves lookups over a valid/ready stream.
- Used by the GF inverse/multiply path of the AES datapath, alongside the exponent table.

Parameters:
- POLY, 8'h1B, low byte of the reduction polynomial used by xtime during table build.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  lookup request valid.
- in_ready  output  1  block can accept a request this cycle.
- a  input  8  field element to take the log of.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- l  output  8  log of a, range 0x00..0xFE; 0x00 when a==0.
- zero  output  1  set with a result when a==0 (log undefined).
- init_done  output  1  table build complete; stays high until the next rst.

Behaviour:
- Reset (rst high at a clock edge):
  - in_ready=0, out_valid=0, l=0x00, zero=0, init_done=0.
  - FSM goes to INIT with p=0x01, i=0x00.
  - RAM contents are don't-care.
- FSM states:
  - INIT: each cycle writes mem[p]<=i, then p<=xtime(p)^p and i<=i+1.
    - xtime(p) = {p[6:0],1'b0} ^ (p[7] ? POLY : 8'h00).
    - The write with i==0xFE is the last one, 255 writes in total; on that cycle the FSM moves to READY.
    - p never reaches 0x00. mem[0x00] is never written and is never read for a result.
  - READY: serves lookups. Terminal until rst.
- init_done goes high on the first cycle in READY, exactly 255 cycles after reset deasserts. in_ready=0 throughout INIT.
- Handshake:
  - in_ready = READY && (!out_valid || out_ready).
  - A request is accepted when in_valid && in_ready.
  - On the next edge: out_valid<=1, l<=mem[a], zero<=0. If a==0x00, instead l<=0x00 and zero<=1.
  - Latency is 1 cycle; throughput is 1 result per cycle when out_ready is held high.
- Backpressure:
  - While out_valid && !out_ready, the result register holds l and zero stable, and in_ready=0.
  - out_valid clears after an out_ready handshake if no new request is accepted in the same cycle.
- Simultaneous out_ready and new accept in the same cycle: the new result replaces the old one with no bubble, and out_valid stays 1.
- in_valid during INIT is ignored: no result is produced and no request is queued.
- rst during INIT or READY: restarts the build from p=0x01, i=0, and drops any pending result (out_valid=0).
- Identity for all a!=0: E[l(a)]==a. l is never 0xFF.

Test Plan:
- Apply reset, hold in_valid=1 throughout -> init_done rises exactly 255 cycles after rst falls; in_ready=0 and out_valid=0 before that.
- After init, directed lookups give:
  - a=0x01 -> l=0x00
  - a=0x03 -> 0x01
  - a=0x05 -> 0x02
  - a=0xFF -> 0x07
  - a=0x1A -> 0x08
  - a=0x02 -> 0x19
  - a=0xF6 -> 0xFE
  - zero=0 for all of these.
- a=0x00 -> l=0x00, zero=1, one cycle after accept.
- Exhaustive sweep: in_valid=1 and out_ready=1 held for a=0x01..0xFF back-to-back -> one result per cycle, and every l exponentiated through the exponent table equals its a. The full set of l values is a permutation of 0x00..0xFE.
- Backpressure: accept a=0x03, then hold out_ready=0 for 5 cycles while in_valid=1 with a=0x05 -> l stays 0x01 and in_ready=0. Raise out_ready -> next cycle l=0x02.
- Assert rst for 1 cycle mid-INIT (cycle 100), and separately while out_valid=1 -> out_valid=0 and init_done=0 immediately. init_done then rises 255 cycles later; a=0x03 then returns 0x01.
